// File: rtl/vram_fill_pkg.sv
// Shared types and default geometry for the vram_fill framebuffer and its fill engine.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 240;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_XY_W   = 10;

  function automatic int unsigned vram_depth(input int unsigned h_res, input int unsigned v_res);
    return h_res * v_res;
  endfunction

endpackage

// File: rtl/vram_fill_if.sv
// CPU-side framebuffer bus: address, strobes, write data, registered read data and stall.
interface vram_fill_if #(
  parameter int ADDR_W = vram_pkg::DEF_ADDR_W,
  parameter int DATA_W = vram_pkg::DEF_DATA_W
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rdata;
  logic              stall;

  modport master (output addr, wdata, we, re, input rdata, stall);
  modport slave  (input addr, wdata, we, re, output rdata, stall);
endinterface

// File: rtl/vram_fill_dp.sv
// Inferred simple dual-port RAM: port A read/write, port B read-only, registered read-before-write.
module vram_dp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [IDX_W-1:0]  addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [IDX_W-1:0]  addr_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (re_a) q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/vram_fill.sv
// Framebuffer with CPU port, display port and one-pixel-per-clock fill engine.
// Optional rectangle fill with clipping is enabled by defining VRAM_RECT_FILL_EN.
//
// state | meaning
// IDLE  | CPU owns port A; fill_rq accepted here
// FILL  | one pixel written per cycle, CPU stalled
// DONE  | fill_ack pulse, back to IDLE
module vram_fill
  import vram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XY_W   = DEF_XY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_rq,
  input  logic [DATA_W-1:0] fill_color,
  input  logic [XY_W-1:0]   fill_x0,
  input  logic [XY_W-1:0]   fill_y0,
  input  logic [XY_W-1:0]   fill_w,
  input  logic [XY_W-1:0]   fill_h,
  output logic              fill_busy,
  output logic              fill_ack,
  vram_fill_if.slave        cpu,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata
);

  localparam int unsigned     DEPTH   = vram_depth(H_RES, V_RES);
  localparam int              IDX_W   = $clog2(DEPTH);
  localparam int              CW      = XY_W + 1;
  localparam logic [CW-1:0]   H_LIM   = CW'(H_RES);
  localparam logic [CW-1:0]   V_LIM   = CW'(V_RES);
  localparam logic [IDX_W-1:0] H_STEP = IDX_W'(H_RES);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  fill_state_t       state;
  logic [CW-1:0]     x_cnt, y_cnt, x_start, x_end, y_end;
  logic [IDX_W-1:0]  row_base;
  logic [DATA_W-1:0] color_q;

  logic [CW-1:0]     x_start_c, y_start_c, x_end_c, y_end_c;
  logic [IDX_W-1:0]  row_start_c;
  logic [CW-1:0]     x_nxt, y_nxt;
  logic [IDX_W-1:0]  fill_addr;
  logic              filling;

`ifdef VRAM_RECT_FILL_EN
  logic [CW-1:0] x_sum, y_sum;
  logic          empty_c;

  // Sums are one bit wider than the coordinates so x0+w never wraps before clipping.
  assign x_sum       = {1'b0, fill_x0} + {1'b0, fill_w};
  assign y_sum       = {1'b0, fill_y0} + {1'b0, fill_h};
  assign x_end_c     = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign y_end_c     = (y_sum > V_LIM) ? V_LIM : y_sum;
  assign x_start_c   = {1'b0, fill_x0};
  assign y_start_c   = {1'b0, fill_y0};
  assign empty_c     = (fill_w == '0) || (fill_h == '0) ||
                       ({1'b0, fill_x0} >= H_LIM) || ({1'b0, fill_y0} >= V_LIM);
  // Constant-coefficient product: reduces to shifts and adds, only used once at accept.
  assign row_start_c = IDX_W'(fill_y0) * H_STEP;
`else
  wire unused_geom = ^{fill_x0, fill_y0, fill_w, fill_h};

  assign x_start_c   = '0;
  assign y_start_c   = '0;
  assign x_end_c     = H_LIM;
  assign y_end_c     = V_LIM;
  assign row_start_c = '0;
`endif

  assign x_nxt     = x_cnt + CW'(1);
  assign y_nxt     = y_cnt + CW'(1);
  assign fill_addr = row_base + IDX_W'(x_cnt);
  assign filling   = (state == FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fill_busy <= 1'b0;
      fill_ack  <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      x_start   <= '0;
      x_end     <= '0;
      y_end     <= '0;
      row_base  <= '0;
      color_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          fill_ack <= 1'b0;
          if (fill_rq) begin
            color_q  <= fill_color;
            x_cnt    <= x_start_c;
            y_cnt    <= y_start_c;
            x_start  <= x_start_c;
            x_end    <= x_end_c;
            y_end    <= y_end_c;
            row_base <= row_start_c;
`ifdef VRAM_RECT_FILL_EN
            if (empty_c) begin
              state    <= DONE;
              fill_ack <= 1'b1;
            end else
`endif
            begin
              state     <= FILL;
              fill_busy <= 1'b1;
            end
          end
        end
        FILL: begin
          if (x_nxt == x_end) begin
            if (y_nxt == y_end) begin
              state     <= DONE;
              fill_busy <= 1'b0;
              fill_ack  <= 1'b1;
            end else begin
              y_cnt    <= y_nxt;
              x_cnt    <= x_start;
              row_base <= row_base + H_STEP;
            end
          end else begin
            x_cnt <= x_nxt;
          end
        end
        DONE: begin
          fill_ack <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic              cpu_in, disp_in;
  logic              we_a, re_a;
  logic [IDX_W-1:0]  addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, q_a, q_b;
  logic              cpu_zero, disp_zero;

  assign cpu_in  = ({1'b0, cpu.addr} < DEPTH_A);
  assign disp_in = ({1'b0, disp_addr} < DEPTH_A);
  assign we_a    = filling | (cpu.we & cpu_in);
  assign re_a    = cpu.re & cpu_in & ~filling;
  assign addr_a  = filling ? fill_addr : cpu.addr[IDX_W-1:0];
  assign wdata_a = filling ? color_q : cpu.wdata;
  assign addr_b  = disp_in ? disp_addr[IDX_W-1:0] : '0;

  vram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_a    (we_a),
    .re_a    (re_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .q_a     (q_a),
    .addr_b  (addr_b),
    .q_b     (q_b)
  );

  // RAM read registers are not reset; these flags force 0 after reset, stalls and out-of-range reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_zero  <= 1'b1;
      disp_zero <= 1'b1;
    end else begin
      if (cpu.re) cpu_zero <= filling | ~cpu_in;
      disp_zero <= ~disp_in;
    end
  end

  assign cpu.rdata  = cpu_zero ? '0 : q_a;
  assign cpu.stall  = filling;
  assign disp_rdata = disp_zero ? '0 : q_b;

endmodule

// File: tb/tb_vram_fill.sv
// Scoreboard bench for vram_fill on a reduced 16x8 frame; read and ack expectations are queued by stimulus.
module tb_vram_fill;
  localparam int DW = 8, HR = 16, VR = 8, AW = 8, XW = 5;
  localparam int NPIX = HR * VR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill_rq = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic [XW-1:0] fill_x0 = '0, fill_y0 = '0, fill_w = '0, fill_h = '0;
  logic fill_busy, fill_ack;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;

  always #5 clk = ~clk;

  vram_fill_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();

  vram_fill #(
    .DATA_W(DW), .H_RES(HR), .V_RES(VR), .ADDR_W(AW), .XY_W(XW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_rq    (fill_rq),
    .fill_color (fill_color),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_busy  (fill_busy),
    .fill_ack   (fill_ack),
    .cpu        (cpu_if),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata)
  );

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t cpu_q[$];
  exp_t disp_q[$];
  int   ack_q[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   busy_cnt = 0, stall_cnt = 0;
  logic rd_pend = 1'b0, disp_pend = 1'b0, disp_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_pend   <= cpu_if.re;
    disp_pend <= disp_chk;
  end

  always @(negedge clk) begin
    exp_t e;
    if (fill_busy) busy_cnt++;
    if (cpu_if.stall) stall_cnt++;
    if (rd_pend) begin
      if (cpu_q.size() == 0) chk("cpu_exp_avail", cpu_q.size(), 1);
      else begin
        e = cpu_q.pop_front();
        chk(e.tag, cpu_if.rdata, e.val);
      end
    end
    if (disp_pend) begin
      if (disp_q.size() == 0) chk("disp_exp_avail", disp_q.size(), 1);
      else begin
        e = disp_q.pop_front();
        chk(e.tag, disp_rdata, e.val);
      end
    end
    if (rst && fill_ack === 1'b1) begin
      if (ack_q.size() == 0) chk("ack_expected", ack_q.size(), 1);
      else chk("ack_cycle", cyc, ack_q.pop_front());
    end
  end

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_if.addr = a; cpu_if.wdata = d; cpu_if.we = 1'b1;
    @(negedge clk);
    cpu_if.we = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] ev, input string tag);
    cpu_if.addr = a; cpu_if.re = 1'b1;
    cpu_q.push_back('{val: ev, tag: tag});
    @(negedge clk);
    cpu_if.re = 1'b0;
  endtask

  task automatic disp_read(input logic [AW-1:0] a, input logic [DW-1:0] ev, input string tag);
    disp_addr = a; disp_chk = 1'b1;
    disp_q.push_back('{val: ev, tag: tag});
    @(negedge clk);
    disp_chk = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge right after the accept edge.
  task automatic start_fill(input logic [DW-1:0] col, input int x0, input int y0, input int w,
                            input int h, input int npix, input bit want_ack);
    fill_color = col;
    fill_x0 = XW'(x0); fill_y0 = XW'(y0); fill_w = XW'(w); fill_h = XW'(h);
    fill_rq = 1'b1;
    busy_cnt = 0; stall_cnt = 0;
    if (want_ack) ack_q.push_back(cyc + 1 + npix);
    @(negedge clk);
    fill_rq = 1'b0;
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    while (fill_ack !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", fill_ack, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_if.addr = '0; cpu_if.wdata = '0; cpu_if.we = 1'b0; cpu_if.re = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", fill_busy, 0);
    chk("rst_ack", fill_ack, 0);
    chk("rst_stall", cpu_if.stall, 0);
    chk("rst_cpu_rdata", cpu_if.rdata, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    cpu_write(8'd100, 8'h5A);
    cpu_write(8'd0, 8'hA1);
    cpu_write(8'd72, 8'h22);
    cpu_write(8'd200, 8'h11);
    cpu_read(8'd100, 8'h5A, "rd100");
    disp_read(8'd100, 8'h5A, "disp100");
    chk("rd_hold", cpu_if.rdata, 8'h5A);
    cpu_read(8'd200, 8'h00, "rd_oor");
    disp_read(8'd200, 8'h00, "disp_oor");
    cpu_read(8'd72, 8'h22, "rd_no_alias");
    cpu_read(8'd100, 8'h5A, "rd100_pre_fill");

    // Full frame fill; a CPU write in the accept cycle still lands.
    cpu_if.addr = 8'd120; cpu_if.wdata = 8'h77; cpu_if.we = 1'b1;
    start_fill(8'h3C, 0, 0, HR, VR, NPIX, 1'b1);
    cpu_if.we = 1'b0;
    chk("stall_in_fill", cpu_if.stall, 1);
    chk("busy_in_fill", fill_busy, 1);
    cpu_if.addr = 8'd100; cpu_if.re = 1'b1;
    cpu_q.push_back('{val: 8'h00, tag: "rd_during_fill"});
    disp_addr = 8'd0; disp_chk = 1'b1;
    disp_q.push_back('{val: 8'hA1, tag: "disp_read_before_write"});
    @(negedge clk);
    cpu_if.re = 1'b0;
    disp_q.push_back('{val: 8'h3C, tag: "disp_after_write"});
    cpu_if.addr = 8'd101; cpu_if.wdata = 8'h99; cpu_if.we = 1'b1;
    @(negedge clk);
    disp_addr = 8'd120;
    disp_q.push_back('{val: 8'h77, tag: "disp_accept_cycle_write"});
    @(negedge clk);
    disp_chk = 1'b0;
    wait_ack(NPIX + 20);
    chk("stall_at_ack", cpu_if.stall, 0);
    @(negedge clk);
    cpu_if.we = 1'b0;
    chk("ack_one_cycle", fill_ack, 0);
    chk("busy_cycles", busy_cnt, NPIX);
    chk("stall_cycles", stall_cnt, NPIX);
    cpu_read(8'd0, 8'h3C, "fill_addr0");
    cpu_read(8'd127, 8'h3C, "fill_addr_last");
    cpu_read(8'd101, 8'h99, "held_write_after_fill");
    cpu_read(8'd120, 8'h3C, "fill_overwrote_120");
    cpu_read(8'd64, 8'h3C, "fill_addr64");

    // Abort at pixel 50: addresses 0..49 written, 50 untouched.
    start_fill(8'h55, 0, 0, HR, VR, NPIX, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", fill_busy, 0);
    chk("abort_stall", cpu_if.stall, 0);
    chk("abort_ack", fill_ack, 0);
    chk("abort_cpu_rdata", cpu_if.rdata, 0);
    chk("abort_disp_rdata", disp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(8'd49, 8'h55, "abort_addr49");
    cpu_read(8'd50, 8'h3C, "abort_addr50");
    start_fill(8'h66, 0, 0, HR, VR, NPIX, 1'b1);
    wait_ack(NPIX + 20);
    @(negedge clk);
    cpu_read(8'd50, 8'h66, "refill_addr50");
    cpu_read(8'd101, 8'h66, "refill_addr101");

`ifdef VRAM_RECT_FILL_EN
    start_fill(8'hFF, 12, 6, 8, 5, 8, 1'b1);
    wait_ack(40);
    @(negedge clk);
    chk("rect_busy_cycles", busy_cnt, 8);
    cpu_read(8'd108, 8'hFF, "rect_first");
    cpu_read(8'd111, 8'hFF, "rect_row_end");
    cpu_read(8'd124, 8'hFF, "rect_row2");
    cpu_read(8'd127, 8'hFF, "rect_last");
    cpu_read(8'd107, 8'h66, "rect_left_outside");
    cpu_read(8'd92, 8'h66, "rect_above_outside");
    cpu_read(8'd123, 8'h66, "rect_row2_left");
    start_fill(8'hAA, 0, 0, 0, 5, 0, 1'b1);
    wait_ack(10);
    @(negedge clk);
    chk("empty_w_busy", busy_cnt, 0);
    start_fill(8'hAA, HR, 0, 4, 4, 0, 1'b1);
    wait_ack(10);
    @(negedge clk);
    chk("empty_x0_busy", busy_cnt, 0);
    cpu_read(8'd0, 8'h66, "empty_no_write");
`else
    start_fill(8'hAA, 3, 2, 0, 0, NPIX, 1'b1);
    wait_ack(NPIX + 20);
    @(negedge clk);
    chk("geom_ignored_busy", busy_cnt, NPIX);
    cpu_read(8'd0, 8'hAA, "geom_ignored_addr0");
    cpu_read(8'd127, 8'hAA, "geom_ignored_last");
`endif

    repeat (3) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_fill.md
# vram_fill

Parametrised video framebuffer with a built-in hardware fill engine: a CPU read/write port, an independent display read port, and a request/acknowledge fill controller that writes one pixel per clock. It sits between the CPU memory bus and the VGA scan-out logic. Compared with the earlier clear-only framebuffer it adds configurable geometry and pixel width, an arbitrary fill colour, registered reads, a CPU stall output and optional rectangle fill.

## Interface
- DATA_W, 8, pixel width in bits
- H_RES, 640, pixels per line
- V_RES, 240, lines per frame; DEPTH = H_RES*V_RES
- ADDR_W, 20, address width; DEPTH must be ≤ 2^ADDR_W
- XY_W, 10, width of rectangle coordinates
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- fill_rq  in  1  fill request, level
- fill_color  in  DATA_W  fill value, latched on accept
- fill_x0, fill_y0, fill_w, fill_h  in  XY_W each  rectangle, latched on accept (ignored without VRAM_RECT_FILL_EN)
- fill_busy  out  1  engine in FILL state
- fill_ack  out  1  one-cycle completion pulse
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_we, cpu_re  in  1  CPU write / read strobes
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_stall  out  1  CPU access not performed this cycle
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  display read data, registered

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: if fill_rq is high, latch the colour and geometry and go to FILL. If the clipped region is empty, go directly to DONE.
- FILL: write the latched colour to one address per cycle, in row-major order.
  - The row base advances by H_RES per row using an adder; no multiplier.
  - After the last pixel, go to DONE.
- DONE: fill_ack = 1 for exactly one cycle, then go to IDLE.
- fill_rq is sampled only in IDLE. A request still high in the IDLE cycle after DONE starts a new fill, so the requester must drop fill_rq on seeing fill_ack.
- Whole-frame fill writes exactly addresses 0..DEPTH-1, with no overrun.
- Clipping (VRAM_RECT_FILL_EN only):
  - Region is empty when w==0, h==0, x0≥H_RES or y0≥V_RES.
  - x_end = min(x0+w, H_RES); y_end = min(y0+h, V_RES).
  - Compute x_end and y_end at XY_W+1 bits so the sum cannot overflow.
- During FILL:
  - cpu_stall = 1 combinationally.
  - CPU writes are dropped; cpu_rdata returns 0.
  - The master must hold its access until cpu_stall falls.
- Out-of-range addresses (≥DEPTH) on either port: writes are ignored and reads return 0.
- The display port is never stalled and is served during FILL.
- In the same cycle, a display read of the address being filled returns the old data (read-before-write).

## Timing
- Reset values: fill_busy 0, fill_ack 0, cpu_stall 0, cpu_rdata 0, disp_rdata 0, state IDLE, counters 0. Memory contents are not reset.
- Read latency is 1 cycle on both ports. cpu_rdata holds its last value when cpu_re is low.
- Fill cycle sequence, for N pixels in the region, with accept at cycle 0:
  - writes at cycles 1..N;
  - fill_busy high during cycles 1..N;
  - fill_ack high at cycle N+1.
- Empty region: fill_ack at cycle 1, no writes, fill_busy stays 0.
- Full frame: fill_ack at cycle DEPTH+1.
- Asserting rst mid-fill aborts immediately: no fill_ack, and the partially filled memory is kept.
- A CPU write in the cycle of fill accept (IDLE, fill_rq high) is performed, because stall begins the next cycle.

## Configuration
- VRAM_RECT_FILL_EN defined: rectangle fill with clipping, as described above.
- VRAM_RECT_FILL_EN undefined:
  - The fill region is always the full frame; the geometry ports are present but unused.
  - The empty-region path and clipping logic are not built.

## Structure
- Package vram_pkg holds:
  - the fill_state_t enum (IDLE, FILL, DONE);
  - default constants H_RES, V_RES, DATA_W, ADDR_W, XY_W;
  - the DEPTH localparam function.
- Sub-module vram_dp: inferred simple dual-port RAM, DEPTH×DATA_W.
  - Port A: read/write, shared by the CPU and the fill mux.
  - Port B: read-only, for display.
  - Registered reads on both ports, read-before-write.
- The top level contains the FSM, address generator, clip logic, port mux and range checks.

## Test plan
- Reset, CPU write 0x5A to address 100, read it back → cpu_rdata = 0x5A one cycle after cpu_re; disp_addr=100 also returns 0x5A.
- Full fill with colour 0x3C, macro undefined → fill_ack at cycle 153601 after accept; addresses 0 and 153599 read 0x3C; no write outside the frame; cpu_stall high for 153600 cycles.
- Rectangle x0=630, y0=238, w=20, h=5, colour 0xFF, macro defined → exactly 10×2 pixels written; address 153599 = 0xFF; address 152969 unchanged.
- Rectangle with w=0 → fill_ack one cycle after accept; no writes; fill_busy never asserted.
- CPU write and read attempted during a fill → cpu_stall=1; the write is dropped; cpu_rdata=0; the same write held until stall falls lands after fill_ack.
- Async reset mid-fill at pixel 500 → outputs return to 0 immediately, no fill_ack; address 499 is filled, address 500 keeps its old value; a new fill_rq works normally.
